// File: rtl/gem_csc_window_match.sv
// rtl/gem_csc_window_match.sv - GEM-CSC window match of projected CLCT keys against GEM clusters
//
// Purpose:
//    Latches the two best CLCTs, picks up the per-layer slope offsets one
//    clock later, projects each CLCT key onto GEM layers A and B (clamped to
//    0..MXKEY-1), then scans a GEM cluster stream and keeps, per CLCT and per
//    layer, the closest cluster whose |delta| fits in match_window_i.
//
// Configuration:
//    CSC_GEM_ME1A_MATCH_EN - defined: ME1a CLCTs are matched like ME1b ones.
//                            undefined: a CLCT flagged ME1a is never eligible.
//
// Ports:
//    clock_i, reset_i              clock, synchronous active-high reset
//    clct_vld_i                    start pulse, CLCT pair valid (IDLE only)
//    clct{0,1}_vpf_i/_xky_i        CLCT valid flag and eighth-strip key
//    isME1a{0,1}_i                 CLCT lies in ME1a
//    clct{0,1}_gem{A,B}_offset_i   signed offsets, valid one cycle after start
//    match_window_i                maximum accepted |delta|
//    gem_vld_i/_layer_i/_pos_i/_last_i  cluster stream (layer 0 = A, 1 = B)
//    gem_rdy_o                     cluster accepted this cycle when gem_vld_i
//    busy_o                        state is not IDLE
//    match_done_o, timeout_o       one-cycle done pulse, scan ended without last
//    clct{0,1}_gem{A,B}_found_o/_dx_o/_pos_o  best match per CLCT and layer

module gem_csc_window_match #(
   parameter int MXKEY = 896,
   parameter int MXCLS = 16,
   parameter int MXWIN = 8
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             clct_vld_i,
   input  logic             clct0_vpf_i,
   input  logic             clct1_vpf_i,
   input  logic [9:0]       clct0_xky_i,
   input  logic [9:0]       clct1_xky_i,
   input  logic             isME1a0_i,
   input  logic             isME1a1_i,
   input  logic [7:0]       clct0_gemA_offset_i,
   input  logic [7:0]       clct0_gemB_offset_i,
   input  logic [7:0]       clct1_gemA_offset_i,
   input  logic [7:0]       clct1_gemB_offset_i,
   input  logic [MXWIN-1:0] match_window_i,
   input  logic             gem_vld_i,
   input  logic             gem_layer_i,
   input  logic [9:0]       gem_pos_i,
   input  logic             gem_last_i,
   output logic             gem_rdy_o,
   output logic             busy_o,
   output logic             match_done_o,
   output logic             timeout_o,
   output logic             clct0_gemA_found_o,
   output logic             clct0_gemB_found_o,
   output logic             clct1_gemA_found_o,
   output logic             clct1_gemB_found_o,
   output logic [7:0]       clct0_gemA_dx_o,
   output logic [7:0]       clct0_gemB_dx_o,
   output logic [7:0]       clct1_gemA_dx_o,
   output logic [7:0]       clct1_gemB_dx_o,
   output logic [9:0]       clct0_gemA_pos_o,
   output logic [9:0]       clct0_gemB_pos_o,
   output logic [9:0]       clct1_gemA_pos_o,
   output logic [9:0]       clct1_gemB_pos_o
);

   localparam int              CW       = (MXCLS > 1) ? $clog2(MXCLS) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(MXCLS - 1);
   localparam logic [11:0]     KEY_MAX  = 12'(MXKEY - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_OFS,
      S_PROJ,
      S_SCAN,
      S_DONE
   } state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic          busy_q;
   logic          rdy_q;
   logic          done_q;
   logic          timeout_q;
   logic [9:0]    xky_q [2];
   logic [1:0]    elig_q;
   logic [1:0]    elig_d;
   logic          start;
   logic          accept;
   logic [7:0]    ofs_in [4];

   // Lane order: 0 = clct0/A, 1 = clct0/B, 2 = clct1/A, 3 = clct1/B.
   assign ofs_in[0] = clct0_gemA_offset_i;
   assign ofs_in[1] = clct0_gemB_offset_i;
   assign ofs_in[2] = clct1_gemA_offset_i;
   assign ofs_in[3] = clct1_gemB_offset_i;

   // ME1a exclusion is folded into the latched eligibility flag.
`ifdef CSC_GEM_ME1A_MATCH_EN
   assign elig_d = {clct1_vpf_i, clct0_vpf_i};
`else
   assign elig_d = {clct1_vpf_i & ~isME1a1_i, clct0_vpf_i & ~isME1a0_i};
`endif

   assign start  = (state_q == S_IDLE) && clct_vld_i;
   assign accept = rdy_q && gem_vld_i;

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         rdy_q     <= 1'b0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         xky_q[0]  <= '0;
         xky_q[1]  <= '0;
         elig_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (clct_vld_i) begin
                  state_q   <= S_WAIT_OFS;
                  busy_q    <= 1'b1;
                  timeout_q <= 1'b0;
                  xky_q[0]  <= clct0_xky_i;
                  xky_q[1]  <= clct1_xky_i;
                  elig_q    <= elig_d;
               end
            end
            S_WAIT_OFS: begin
               state_q <= S_PROJ;
            end
            S_PROJ: begin
               state_q <= S_SCAN;
               rdy_q   <= 1'b1;
               cnt_q   <= '0;
            end
            S_SCAN: begin
               cnt_q <= cnt_q + 1'b1;
               if (accept && gem_last_i) begin
                  state_q <= S_DONE;
                  rdy_q   <= 1'b0;
                  done_q  <= 1'b1;
               end else if (cnt_q == CNT_LAST) begin
                  state_q   <= S_DONE;
                  rdy_q     <= 1'b0;
                  done_q    <= 1'b1;
                  timeout_q <= 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               rdy_q   <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_lane
      localparam int   CL    = g / 2;
      localparam logic LAYER = 1'(g % 2);

      logic [7:0]         ofs_q;
      logic [9:0]         proj_q;
      logic               found_q;
      logic [7:0]         dx_q;
      logic [9:0]         pos_q;
      logic signed [11:0] proj_raw;
      logic [9:0]         proj_clamped;
      logic [10:0]        delta;
      logic               hit;

      always_comb begin
         proj_raw = $signed({2'b00, xky_q[CL]}) + $signed({{4{ofs_q[7]}}, ofs_q});
         if (proj_raw[11]) begin
            proj_clamped = '0;
         end else if ($unsigned(proj_raw) > KEY_MAX) begin
            proj_clamped = KEY_MAX[9:0];
         end else begin
            proj_clamped = proj_raw[9:0];
         end
      end

      always_comb begin
         if (gem_pos_i >= proj_q) begin
            delta = {1'b0, gem_pos_i} - {1'b0, proj_q};
         end else begin
            delta = {1'b0, proj_q} - {1'b0, gem_pos_i};
         end
         // Strict less-than keeps the earlier cluster on equal deltas.
         hit = accept && elig_q[CL] && (gem_layer_i == LAYER)
               && (delta <= 11'(match_window_i))
               && (!found_q || (delta < {3'b000, dx_q}));
      end

      always_ff @(posedge clock_i) begin
         if (reset_i) begin
            ofs_q   <= '0;
            proj_q  <= '0;
            found_q <= 1'b0;
            dx_q    <= '0;
            pos_q   <= '0;
         end else begin
            if (state_q == S_WAIT_OFS) begin
               ofs_q <= ofs_in[g];
            end
            if (state_q == S_PROJ) begin
               proj_q <= proj_clamped;
            end
            if (start) begin
               found_q <= 1'b0;
               dx_q    <= '0;
               pos_q   <= '0;
            end else if (hit) begin
               found_q <= 1'b1;
               dx_q    <= delta[7:0];
               pos_q   <= gem_pos_i;
            end
         end
      end
   end

   assign gem_rdy_o    = rdy_q;
   assign busy_o       = busy_q;
   assign match_done_o = done_q;
   assign timeout_o    = timeout_q;

   assign clct0_gemA_found_o = g_lane[0].found_q;
   assign clct0_gemB_found_o = g_lane[1].found_q;
   assign clct1_gemA_found_o = g_lane[2].found_q;
   assign clct1_gemB_found_o = g_lane[3].found_q;
   assign clct0_gemA_dx_o    = g_lane[0].dx_q;
   assign clct0_gemB_dx_o    = g_lane[1].dx_q;
   assign clct1_gemA_dx_o    = g_lane[2].dx_q;
   assign clct1_gemB_dx_o    = g_lane[3].dx_q;
   assign clct0_gemA_pos_o   = g_lane[0].pos_q;
   assign clct0_gemB_pos_o   = g_lane[1].pos_q;
   assign clct1_gemA_pos_o   = g_lane[2].pos_q;
   assign clct1_gemB_pos_o   = g_lane[3].pos_q;

endmodule

// File: tb/tb_gem_csc_window_match.sv
// tb/tb_gem_csc_window_match.sv - directed table-driven bench for gem_csc_window_match

module tb_gem_csc_window_match;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       clct_vld = 1'b0;
   logic       vpf0 = 1'b0, vpf1 = 1'b0;
   logic [9:0] xky0 = '0, xky1 = '0;
   logic       me0 = 1'b0, me1 = 1'b0;
   logic [7:0] o0a = '0, o0b = '0, o1a = '0, o1b = '0;
   logic [7:0] window = 8'd8;
   logic       gem_vld = 1'b0;
   logic       gem_layer = 1'b0;
   logic [9:0] gem_pos = '0;
   logic       gem_last = 1'b0;
   logic       gem_rdy, busy, done, timeout;
   logic       f0a, f0b, f1a, f1b;
   logic [7:0] d0a, d0b, d1a, d1b;
   logic [9:0] p0a, p0b, p1a, p1b;

   logic [3:0] found_v;
   logic [7:0] dx_v [4];
   logic [9:0] pos_v [4];

   assign found_v  = {f1b, f1a, f0b, f0a};
   assign dx_v[0]  = d0a;
   assign dx_v[1]  = d0b;
   assign dx_v[2]  = d1a;
   assign dx_v[3]  = d1b;
   assign pos_v[0] = p0a;
   assign pos_v[1] = p0b;
   assign pos_v[2] = p1a;
   assign pos_v[3] = p1b;

   always #5 clock = ~clock;

   gem_csc_window_match #(.MXKEY(896), .MXCLS(16), .MXWIN(8)) dut (
      .clock_i(clock), .reset_i(reset), .clct_vld_i(clct_vld),
      .clct0_vpf_i(vpf0), .clct1_vpf_i(vpf1),
      .clct0_xky_i(xky0), .clct1_xky_i(xky1),
      .isME1a0_i(me0), .isME1a1_i(me1),
      .clct0_gemA_offset_i(o0a), .clct0_gemB_offset_i(o0b),
      .clct1_gemA_offset_i(o1a), .clct1_gemB_offset_i(o1b),
      .match_window_i(window),
      .gem_vld_i(gem_vld), .gem_layer_i(gem_layer), .gem_pos_i(gem_pos), .gem_last_i(gem_last),
      .gem_rdy_o(gem_rdy), .busy_o(busy), .match_done_o(done), .timeout_o(timeout),
      .clct0_gemA_found_o(f0a), .clct0_gemB_found_o(f0b),
      .clct1_gemA_found_o(f1a), .clct1_gemB_found_o(f1b),
      .clct0_gemA_dx_o(d0a), .clct0_gemB_dx_o(d0b),
      .clct1_gemA_dx_o(d1a), .clct1_gemB_dx_o(d1b),
      .clct0_gemA_pos_o(p0a), .clct0_gemB_pos_o(p0b),
      .clct1_gemA_pos_o(p1a), .clct1_gemB_pos_o(p1b)
   );

   // Lane order in expectations: 0 = clct0/A, 1 = clct0/B, 2 = clct1/A, 3 = clct1/B.
   typedef struct packed {
      logic [9:0]       xky0;
      logic             vpf0;
      logic             me0;
      logic [9:0]       xky1;
      logic             vpf1;
      logic             me1;
      logic [3:0][7:0]  ofs;
      logic [7:0]       win;
      logic [2:0]       ncls;
      logic [3:0][9:0]  cpos;
      logic [3:0]       clay;
      logic [3:0]       efound;
      logic [3:0][7:0]  edx;
      logic [3:0][9:0]  epos;
   } vec_t;

   localparam int NVEC = 7;
   vec_t vecs [NVEC];

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic setv(input int n,
                       input logic [9:0] x0, input logic v0, input logic m0,
                       input logic [9:0] x1, input logic v1, input logic m1,
                       input logic [7:0] a0, input logic [7:0] b0,
                       input logic [7:0] a1, input logic [7:0] b1,
                       input logic [7:0] w, input logic [2:0] nc);
      vecs[n]      = '0;
      vecs[n].xky0 = x0;
      vecs[n].vpf0 = v0;
      vecs[n].me0  = m0;
      vecs[n].xky1 = x1;
      vecs[n].vpf1 = v1;
      vecs[n].me1  = m1;
      vecs[n].ofs  = {b1, a1, b0, a0};
      vecs[n].win  = w;
      vecs[n].ncls = nc;
   endtask

   task automatic setc(input int n, input logic [1:0] k, input logic l, input logic [9:0] p);
      vecs[n].clay[k] = l;
      vecs[n].cpos[k] = p;
   endtask

   task automatic sete(input int n, input logic [1:0] i, input logic f,
                       input logic [7:0] d, input logic [9:0] p);
      vecs[n].efound[i] = f;
      vecs[n].edx[i]    = d;
      vecs[n].epos[i]   = p;
   endtask

   task automatic chk_zero(input string pfx);
      chk({pfx, "_busy"}, int'(busy), 0);
      chk({pfx, "_rdy"}, int'(gem_rdy), 0);
      chk({pfx, "_done"}, int'(done), 0);
      chk({pfx, "_timeout"}, int'(timeout), 0);
      chk({pfx, "_found"}, int'(found_v), 0);
      chk({pfx, "_dxpos"}, int'(|{d0a, d0b, d1a, d1b, p0a, p0b, p1a, p1b}), 0);
   endtask

   task automatic run_vec(input int n);
      vec_t v;
      int   nc;
      v  = vecs[n];
      nc = int'(v.ncls);
      xky0 = v.xky0; vpf0 = v.vpf0; me0 = v.me0;
      xky1 = v.xky1; vpf1 = v.vpf1; me1 = v.me1;
      o0a = v.ofs[0]; o0b = v.ofs[1]; o1a = v.ofs[2]; o1b = v.ofs[3];
      window = v.win;
      clct_vld = 1'b1;
      @(posedge clock); #1;
      clct_vld = 1'b0;
      chk($sformatf("v%0d_busy_wait", n), int'(busy), 1);
      chk($sformatf("v%0d_rdy_wait", n), int'(gem_rdy), 0);
      @(posedge clock); #1;
      chk($sformatf("v%0d_rdy_proj", n), int'(gem_rdy), 0);
      @(posedge clock); #1;
      chk($sformatf("v%0d_rdy_scan", n), int'(gem_rdy), 1);
      for (int k = 0; k < nc; k++) begin
         gem_vld   = 1'b1;
         gem_layer = v.clay[k];
         gem_pos   = v.cpos[k];
         gem_last  = (k == nc - 1);
         @(posedge clock); #1;
         if (k < nc - 1) chk($sformatf("v%0d_early_done%0d", n, k), int'(done), 0);
      end
      gem_vld  = 1'b0;
      gem_last = 1'b0;
      chk($sformatf("v%0d_done", n), int'(done), 1);
      chk($sformatf("v%0d_timeout", n), int'(timeout), 0);
      for (int j = 0; j < 4; j++) begin
         chk($sformatf("v%0d_found%0d", n, j), int'(found_v[j]), int'(v.efound[j]));
         chk($sformatf("v%0d_dx%0d", n, j), int'(dx_v[j]), int'(v.edx[j]));
         chk($sformatf("v%0d_pos%0d", n, j), int'(pos_v[j]), int'(v.epos[j]));
      end
      @(posedge clock); #1;
      chk($sformatf("v%0d_done_pulse", n), int'(done), 0);
      chk($sformatf("v%0d_busy_idle", n), int'(busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  cnt;
      bit  got;
      bit  seen;

      // Projection 400+12=412, cluster 405 -> dx 7.
      setv(0, 10'd400, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 8'h0C, 8'h00, 8'h00, 8'h00, 8'd8, 3'd1);
      setc(0, 2'd0, 1'b0, 10'd405);
      sete(0, 2'd0, 1'b1, 8'd7, 10'd405);
      // Clamping: 3-20 -> 0; 890+20 -> 895.
      setv(1, 10'd3, 1'b1, 1'b0, 10'd890, 1'b1, 1'b0, 8'hEC, 8'h00, 8'h00, 8'h14, 8'd8, 3'd2);
      setc(1, 2'd0, 1'b0, 10'd0);
      setc(1, 2'd1, 1'b1, 10'd895);
      sete(1, 2'd0, 1'b1, 8'd0, 10'd0);
      sete(1, 2'd3, 1'b1, 8'd0, 10'd895);
      // Best and tie: proj 300 and 302 share clusters 306, 297, 303, 320.
      setv(2, 10'd300, 1'b1, 1'b0, 10'd302, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'd8, 3'd4);
      setc(2, 2'd0, 1'b0, 10'd306);
      setc(2, 2'd1, 1'b0, 10'd297);
      setc(2, 2'd2, 1'b0, 10'd303);
      setc(2, 2'd3, 1'b0, 10'd320);
      sete(2, 2'd0, 1'b1, 8'd3, 10'd297);
      sete(2, 2'd2, 1'b1, 8'd1, 10'd303);
      // Window 8 rejects dx 9; clct1 vpf=0 ignores exact hit; layer B hit.
      setv(3, 10'd500, 1'b1, 1'b0, 10'd509, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'd8, 3'd2);
      setc(3, 2'd0, 1'b0, 10'd509);
      setc(3, 2'd1, 1'b1, 10'd500);
      sete(3, 2'd1, 1'b1, 8'd0, 10'd500);
      // Window 9 accepts dx 9 exactly.
      setv(4, 10'd500, 1'b1, 1'b0, 10'd509, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'd9, 3'd1);
      setc(4, 2'd0, 1'b0, 10'd509);
      sete(4, 2'd0, 1'b1, 8'd9, 10'd509);
      // ME1a on clct0 only; clct1 always matches.
      setv(5, 10'd600, 1'b1, 1'b1, 10'd600, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'd8, 3'd1);
      setc(5, 2'd0, 1'b0, 10'd600);
      sete(5, 2'd2, 1'b1, 8'd0, 10'd600);
`ifdef CSC_GEM_ME1A_MATCH_EN
      sete(5, 2'd0, 1'b1, 8'd0, 10'd600);
`endif
      // Unclamped offsets: 200-10=190 (B hit 195), 100+127=227 (A hit 230).
      setv(6, 10'd200, 1'b1, 1'b0, 10'd100, 1'b1, 1'b0, 8'h00, 8'hF6, 8'h7F, 8'h00, 8'd8, 3'd2);
      setc(6, 2'd0, 1'b0, 10'd230);
      setc(6, 2'd1, 1'b1, 10'd195);
      sete(6, 2'd1, 1'b1, 8'd5, 10'd195);
      sete(6, 2'd2, 1'b1, 8'd3, 10'd230);

      repeat (2) @(posedge clock);
      #1;
      chk_zero("init");
      reset = 1'b0;
      @(posedge clock); #1;

      for (int n = 0; n < NVEC; n++) run_vec(n);

      // Timeout with a second clct_vld while busy.
      xky0 = 10'd400; vpf0 = 1'b1; me0 = 1'b0; vpf1 = 1'b0; me1 = 1'b0;
      o0a = '0; o0b = '0; o1a = '0; o1b = '0; window = 8'd8;
      clct_vld = 1'b1;
      @(posedge clock); #1;
      clct_vld = 1'b0;
      cnt = 0;
      got = 1'b0;
      while (cnt < 40 && !got) begin
         if (cnt == 2) begin
            gem_vld = 1'b1; gem_layer = 1'b0; gem_pos = 10'd401; gem_last = 1'b0;
         end
         if (cnt == 4) begin
            clct_vld = 1'b1; xky0 = 10'd100;
         end
         if (cnt == 5) clct_vld = 1'b0;
         @(posedge clock); #1;
         cnt++;
         if (done) got = 1'b1;
      end
      gem_vld  = 1'b0;
      clct_vld = 1'b0;
      chk("to_latency", cnt, 18);
      chk("to_timeout", int'(timeout), 1);
      chk("to_found", int'(f0a), 1);
      chk("to_dx", int'(d0a), 1);
      chk("to_pos", int'(p0a), 401);
      @(posedge clock); #1;
      chk("to_idle_busy", int'(busy), 0);

      // Reset in the middle of a scan.
      xky0 = 10'd400; vpf0 = 1'b1;
      clct_vld = 1'b1;
      @(posedge clock); #1;
      clct_vld = 1'b0;
      cnt = 0;
      while (cnt < 5) begin
         if (cnt == 2) begin
            gem_vld = 1'b1; gem_layer = 1'b0; gem_pos = 10'd400; gem_last = 1'b0;
         end
         if (cnt == 4) reset = 1'b1;
         @(posedge clock); #1;
         cnt++;
         if (cnt == 3) chk("rst_partial_found", int'(f0a), 1);
      end
      chk_zero("rst_mid");
      reset   = 1'b0;
      gem_vld = 1'b0;
      seen    = 1'b0;
      repeat (25) begin
         @(posedge clock); #1;
         if (done) seen = 1'b1;
      end
      chk("rst_no_done", int'(seen), 0);

      run_vec(0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
